// File: rtl/spi_slave_core.sv
// spi_slave_core: SPI mode 0 responder with clk-domain oversampling and TX/RX FIFOs
module spi_slave_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  logic         do_push, do_pop;
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end
endmodule

module spi_slave_core #(
  parameter int               WIDTH       = 8,
  parameter int               TxFIFODepth = 8,
  parameter int               RxFIFODepth = 8,
  parameter logic [WIDTH-1:0] FILL        = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CS_n,
  input  logic             SCK,
  input  logic             MOSI,
  output logic             MISO,
  output logic [WIDTH-1:0] RXdata,
  input  logic             readEn,
  output logic             RXFIFOempty,
  output logic             RXFIFOfull,
  input  logic [WIDTH-1:0] TXdata,
  input  logic             writeEn,
  output logic             TXFIFOempty,
  output logic             TXFIFOfull,
  output logic             busy,
  output logic             wordDone,
  output logic             overflow,
  output logic             underrun,
  input  logic             clearErr
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_e;
  state_e           state_q, state_d;
  logic [2:0]       cs_q, sck_q;
  logic [1:0]       mosi_q, warm_q;
  logic             armed_q;
  logic [WIDTH-1:0] shift_in_q, shift_in_d, shift_out_q, shift_out_d, tx_head;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             push_q, push_d, ovf_q, ovf_d, unr_q, unr_d;
  logic             load, sck_rise, sck_fall;
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign busy     = state_q != IDLE;
  assign MISO     = busy & shift_out_q[WIDTH-1];
  assign wordDone = push_q;
  assign overflow = ovf_q;
  assign underrun = unr_q;
  spi_slave_fifo #(.W(WIDTH), .DEPTH(TxFIFODepth)) u_tx (
    .clk(clk), .rst(rst), .push_i(writeEn), .data_i(TXdata), .pop_i(load),
    .data_o(tx_head), .empty_o(TXFIFOempty), .full_o(TXFIFOfull)
  );
  spi_slave_fifo #(.W(WIDTH), .DEPTH(RxFIFODepth)) u_rx (
    .clk(clk), .rst(rst), .push_i(push_q), .data_i(shift_in_q), .pop_i(readEn),
    .data_o(RXdata), .empty_o(RXFIFOempty), .full_o(RXFIFOfull)
  );
  always_comb begin
    state_d     = state_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    bit_cnt_d   = bit_cnt_q;
    push_d      = 1'b0;
    load        = 1'b0;
    if (state_q != IDLE && cs_q[1]) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
    end else if (state_q == IDLE) begin
      state_d = (armed_q && !cs_q[1]) ? LOAD : IDLE;
    end else if (state_q == LOAD) begin
      load    = 1'b1;
      state_d = SHIFT;
    end else if (sck_rise) begin
      shift_in_d = {shift_in_q[WIDTH-2:0], mosi_q[1]};
      bit_cnt_d  = bit_cnt_q + 1'b1;
      push_d     = bit_cnt_q == CW'(WIDTH - 1);
    end else if (sck_fall) begin
      load        = bit_cnt_q == CW'(WIDTH);
      shift_out_d = shift_out_q << 1;
    end
    if (load) begin
      shift_out_d = TXFIFOempty ? FILL : tx_head;
      bit_cnt_d   = '0;
    end
    ovf_d = (push_q & RXFIFOfull) | (ovf_q & ~clearErr);
    unr_d = (load & TXFIFOempty) | (unr_q & ~clearErr);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q        <= '1;
      sck_q       <= '0;
      mosi_q      <= '0;
      warm_q      <= '0;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      bit_cnt_q   <= '0;
      push_q      <= 1'b0;
      ovf_q       <= 1'b0;
      unr_q       <= 1'b0;
    end else begin
      cs_q        <= {cs_q[1:0], CS_n};
      sck_q       <= {sck_q[1:0], SCK};
      mosi_q      <= {mosi_q[0], MOSI};
      warm_q      <= {warm_q[0], 1'b1};
      armed_q     <= armed_q | (warm_q[1] & cs_q[1]);
      state_q     <= state_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      bit_cnt_q   <= bit_cnt_d;
      push_q      <= push_d;
      ovf_q       <= ovf_d;
      unr_q       <= unr_d;
    end
  end
endmodule

// File: tb/tb_spi_slave_core.sv
// tb_spi_slave_core: frame-level reference model check of spi_slave_core driven by a bit-banged SPI master
module tb_spi_slave_core;
  localparam int H = 4;
  localparam logic [7:0] FILLV = 8'hFF;
  logic clk = 0, rst = 1, CS_n = 1, SCK = 0, MOSI = 0, readEn = 0, writeEn = 0, clearErr = 0;
  logic MISO, RXFIFOempty, RXFIFOfull, TXFIFOempty, TXFIFOfull, busy, wordDone, overflow, underrun;
  logic [7:0] RXdata, TXdata = 0;
  logic [7:0] mo [16];
  logic [7:0] txq[$], rxq[$];
  logic m_ovf = 0, m_unr = 0;
  int vectors = 0, errors = 0, wd_cnt = 0, wd_exp = 0;
  spi_slave_core #(.WIDTH(8), .TxFIFODepth(8), .RxFIFODepth(8), .FILL(FILLV)) dut (
    .clk(clk), .rst(rst), .CS_n(CS_n), .SCK(SCK), .MOSI(MOSI), .MISO(MISO),
    .RXdata(RXdata), .readEn(readEn), .RXFIFOempty(RXFIFOempty), .RXFIFOfull(RXFIFOfull),
    .TXdata(TXdata), .writeEn(writeEn), .TXFIFOempty(TXFIFOempty), .TXFIFOfull(TXFIFOfull),
    .busy(busy), .wordDone(wordDone), .overflow(overflow), .underrun(underrun), .clearErr(clearErr)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (wordDone === 1'b1) wd_cnt++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic check_flags(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_miso_idle"}, MISO, 0);
    check({tag, "_overflow"}, overflow, m_ovf);
    check({tag, "_underrun"}, underrun, m_unr);
    check({tag, "_rx_empty"}, RXFIFOempty, rxq.size() == 0);
    check({tag, "_rx_full"}, RXFIFOfull, rxq.size() == 8);
    check({tag, "_tx_empty"}, TXFIFOempty, txq.size() == 0);
    check({tag, "_tx_full"}, TXFIFOfull, txq.size() == 8);
  endtask
  task automatic tx_push(input logic [7:0] d);
    TXdata = d;
    writeEn = 1;
    @(negedge clk);
    writeEn = 0;
    if (txq.size() < 8) txq.push_back(d);
  endtask
  task automatic rx_drain(input string tag);
    while (rxq.size() != 0) begin
      check({tag, "_rxdata"}, RXdata, rxq.pop_front());
      readEn = 1;
      @(negedge clk);
      readEn = 0;
    end
    check({tag, "_drained"}, RXFIFOempty, 1);
  endtask
  task automatic clear_err();
    clearErr = 1;
    @(negedge clk);
    clearErr = 0;
    m_ovf = 0;
    m_unr = 0;
  endtask
  task automatic spi_bit(input logic mo_b, output logic mi_b);
    MOSI = mo_b;
    repeat (H) @(negedge clk);
    SCK = 1;
    mi_b = MISO;
    repeat (H) @(negedge clk);
    SCK = 0;
  endtask
  task automatic frame(input string tag, input int n, input int partial);
    logic [7:0] exp_miso[$];
    logic [7:0] mi;
    logic b;
    for (int k = 0; k < n + 1; k++) begin
      if (txq.size() != 0) exp_miso.push_back(txq.pop_front());
      else begin
        exp_miso.push_back(FILLV);
        m_unr = 1;
      end
    end
    for (int k = 0; k < n; k++) begin
      if (rxq.size() == 8) m_ovf = 1;
      else rxq.push_back(mo[k]);
    end
    wd_exp += n;
    CS_n = 0;
    repeat (8) @(negedge clk);
    check({tag, "_busy_active"}, busy, 1);
    for (int w = 0; w < n; w++) begin
      for (int i = 7; i >= 0; i--) begin
        spi_bit(mo[w][i], b);
        mi[i] = b;
      end
      check($sformatf("%s_miso_w%0d", tag, w), mi, exp_miso[w]);
    end
    for (int i = 7; i > 7 - partial; i--) spi_bit(mo[n][i], b);
    repeat (H) @(negedge clk);
    CS_n = 1;
    repeat (8) @(negedge clk);
    check({tag, "_word_done_count"}, wd_cnt, wd_exp);
    check_flags(tag);
  endtask
  initial begin
    logic b;
    int k, n;
    repeat (3) @(negedge clk);
    rst = 0;
    check("reset_word_done", wordDone, 0);
    check_flags("reset");
    repeat (5) @(negedge clk);
    tx_push(8'hA5);
    mo[0] = 8'h3C;
    frame("t1", 1, 0);
    rx_drain("t1");
    tx_push(8'h01);
    tx_push(8'h02);
    tx_push(8'h03);
    mo[0] = 8'hF0;
    mo[1] = 8'h0F;
    mo[2] = 8'hAA;
    frame("t2", 3, 0);
    rx_drain("t2");
    clear_err();
    check_flags("t3_pre");
    mo[0] = 8'($urandom);
    frame("t3", 1, 0);
    clear_err();
    check_flags("t3_clear");
    rx_drain("t3");
    for (int r = 0; r < 3; r++) begin
      k = $urandom_range(0, 4);
      n = $urandom_range(1, 4);
      for (int j = 0; j < k; j++) tx_push(8'($urandom));
      for (int j = 0; j < n; j++) mo[j] = 8'($urandom);
      frame($sformatf("rnd%0d", r), n, 0);
      rx_drain($sformatf("rnd%0d", r));
    end
    clear_err();
    for (int j = 0; j < 9; j++) tx_push(8'($urandom));
    check_flags("t4_txfull");
    for (int j = 0; j < 8; j++) mo[j] = 8'($urandom);
    frame("t4_fill", 8, 0);
    mo[0] = 8'h55;
    frame("t4_ovf", 1, 0);
    rx_drain("t4");
    mo[0] = 8'($urandom);
    frame("t5_partial", 0, 5);
    mo[0] = 8'hC3;
    frame("t5_next", 1, 0);
    tx_push(8'h11);
    tx_push(8'h22);
    CS_n = 0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) spi_bit(1'($urandom), b);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    txq.delete();
    rxq.delete();
    m_ovf = 0;
    m_unr = 0;
    check("t6_word_done", wordDone, 0);
    check_flags("t6_reset");
    for (int i = 0; i < 13; i++) begin
      spi_bit(1'($urandom), b);
      check("t6_miso_ignored", b, 0);
    end
    repeat (H) @(negedge clk);
    CS_n = 1;
    repeat (8) @(negedge clk);
    check("t6_word_done_count", wd_cnt, wd_exp);
    check_flags("t6_after");
    tx_push(8'($urandom));
    mo[0] = 8'($urandom);
    frame("t6_next", 1, 0);
    rx_drain("t6");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
